// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//
// Shares the single-port data SRAM between the CPU pipeline MEM stage and
// the external host access port. The CPU normally wins contention; a
// saturating starvation counter lets a waiting host through for one cycle
// after MAX_WAIT consecutive losses. The SRAM has one cycle of read latency,
// so a small FSM remembers who owns the read in flight and routes the
// returning data to that requester only.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   cpu_req/wen/addr/wdata    CPU MEM-stage request
//   cpu_stall                 CPU lost arbitration this cycle, hold pipeline
//   cpu_rvalid/cpu_rdata      CPU read return (rdata holds when not valid)
//   host_req/wen/addr/wdata   host request
//   host_ack                  host granted this cycle
//   host_rvalid/host_rdata    host read return (rdata holds when not valid)
//   mem_en/wen/addr/wdata     SRAM strobe, write enable, address, write data
//   mem_rdata                 SRAM read data, one cycle after a read strobe

module dmem_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              host_req,
    input  logic              host_wen,
    input  logic [31:0]       host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,

    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        CPU_RD,
        HOST_RD
    } rd_state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic              cpu_grant;
    logic              host_grant;
    logic [3:0]        wait_cnt;
    rd_state_t         state;
    rd_state_t         state_next;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] host_rdata_q;

    // Upper address bits are deliberately dropped; the SRAM is word-indexed
    // by the low ADDR_W bits only.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{cpu_addr[31:ADDR_W], host_addr[31:ADDR_W]};

    // Grant is decided in the same cycle as the request. Reset masks both
    // grants so nothing reaches the SRAM while rst is high.
    always_comb begin
        cpu_grant  = 1'b0;
        host_grant = 1'b0;
        if (!rst) begin
            if (cpu_req && host_req) begin
                if (wait_cnt >= WAIT_LIMIT) begin
                    host_grant = 1'b1;
                end else begin
                    cpu_grant = 1'b1;
                end
            end else if (cpu_req) begin
                cpu_grant = 1'b1;
            end else if (host_req) begin
                host_grant = 1'b1;
            end
        end
    end

    // SRAM request mux; the bus is driven to zero when nobody owns it.
    always_comb begin
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_grant) begin
            mem_wen   = cpu_wen;
            mem_addr  = cpu_addr[ADDR_W-1:0];
            mem_wdata = cpu_wdata;
        end else if (host_grant) begin
            mem_wen   = host_wen;
            mem_addr  = host_addr[ADDR_W-1:0];
            mem_wdata = host_wdata;
        end
    end

    assign mem_en    = cpu_grant | host_grant;
    assign cpu_stall = cpu_req & ~cpu_grant;
    assign host_ack  = host_grant;

    // Starvation counter: counts consecutive cycles the host asked and lost.
    // It saturates at the limit so the comparison above stays true until the
    // host actually wins; withdrawing the request forgets the history.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (host_req && !host_grant) begin
            if (wait_cnt < WAIT_LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end else begin
            wait_cnt <= 4'd0;
        end
    end

    // Read-owner register: records which requester's read is returning next
    // cycle. Every state can go to every other because reads are pipelined.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next owner and read-return strobes. rvalid is masked by rst so a read
    // granted just before reset never reports a return.
    always_comb begin
        state_next = IDLE;
        if (cpu_grant && !cpu_wen) begin
            state_next = CPU_RD;
        end else if (host_grant && !host_wen) begin
            state_next = HOST_RD;
        end
        cpu_rvalid  = (state == CPU_RD)  && !rst;
        host_rvalid = (state == HOST_RD) && !rst;
    end

    // Each port shows live SRAM data while it owns the return and otherwise
    // holds the last word it received, so the other port's reads never leak.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (host_rvalid) begin
                host_rdata_q <= mem_rdata;
            end
        end
    end

    assign cpu_rdata  = cpu_rvalid  ? mem_rdata : cpu_rdata_q;
    assign host_rdata = host_rvalid ? mem_rdata : host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with a behavioural one-cycle-latency SRAM.
// Inputs change on the falling edge; outputs are sampled 1 ns later, so
// combinational grant outputs belong to the current cycle and rvalid/rdata
// reflect the read granted in the previous cycle.

module tb_dmem_arbiter;

    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk;
    logic              rst;
    logic              cpu_req;
    logic              cpu_wen;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              host_req;
    logic              host_wen;
    logic [31:0]       host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;
    logic              mem_en;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];

    dmem_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_wen    (cpu_wen),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .host_req   (host_req),
        .host_wen   (host_wen),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .mem_en     (mem_en),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM: writes commit at the edge, reads return
    // on the next cycle and hold until the next read.
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) sram[i] = '0;
        mem_rdata = '0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wen) sram[mem_addr] <= mem_wdata;
            else         mem_rdata <= sram[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation timeout");
    end

    task automatic applyStimulus(input logic creq, input logic cwen,
                                 input logic [31:0] caddr, input logic [31:0] cwdata,
                                 input logic hreq, input logic hwen,
                                 input logic [31:0] haddr, input logic [31:0] hwdata);
        @(negedge clk);
        cpu_req    = creq;
        cpu_wen    = cwen;
        cpu_addr   = caddr;
        cpu_wdata  = cwdata;
        host_req   = hreq;
        host_wen   = hwen;
        host_addr  = haddr;
        host_wdata = hwdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 0; cpu_wen = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_wen = 0; host_addr = 0; host_wdata = 0;

        // Reset with both requesters asking: nothing may be granted.
        applyStimulus(1, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0);
        applyStimulus(1, 0, 32'h0, 32'h0, 1, 0, 32'h0, 32'h0);
        checkOutput("rst_mem_en",      32'(mem_en),      32'd0);
        checkOutput("rst_host_ack",    32'(host_ack),    32'd0);
        checkOutput("rst_cpu_stall",   32'(cpu_stall),   32'd1);
        checkOutput("rst_cpu_rvalid",  32'(cpu_rvalid),  32'd0);
        checkOutput("rst_host_rvalid", 32'(host_rvalid), 32'd0);
        checkOutput("rst_cpu_rdata",   cpu_rdata,        32'd0);
        checkOutput("rst_host_rdata",  host_rdata,       32'd0);

        // Release: CPU wins the first contended cycle.
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rel_cpu_stall", 32'(cpu_stall), 32'd0);
        checkOutput("rel_host_ack",  32'(host_ack),  32'd0);
        checkOutput("rel_mem_en",    32'(mem_en),    32'd1);

        // CPU write then read of 0x10.
        applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0);
        checkOutput("cw_cpu_stall", 32'(cpu_stall), 32'd0);
        checkOutput("cw_mem_wen",   32'(mem_wen),   32'd1);
        checkOutput("cw_mem_addr",  32'(mem_addr),  32'h10);
        checkOutput("cw_mem_wdata", mem_wdata,      32'hDEADBEEF);
        applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        checkOutput("cr_cpu_stall",  32'(cpu_stall),  32'd0);
        checkOutput("cr_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        checkOutput("cr_mem_en_idle", 32'(mem_en),      32'd0);
        checkOutput("cr_rvalid",      32'(cpu_rvalid),  32'd1);
        checkOutput("cr_rdata",       cpu_rdata,        32'hDEADBEEF);
        checkOutput("cr_host_rvalid", 32'(host_rvalid), 32'd0);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        checkOutput("cr_rvalid_drop", 32'(cpu_rvalid), 32'd0);
        checkOutput("cr_rdata_hold",  cpu_rdata,       32'hDEADBEEF);

        // Preload 0x20 from the host, then contend for ten cycles.
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 1, 32'h20, 32'h12345678);
        checkOutput("hw_host_ack", 32'(host_ack), 32'd1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
            checkOutput($sformatf("ct_host_ack_%0d", i),  32'(host_ack),  32'((i % 5) == 4));
            checkOutput($sformatf("ct_cpu_stall_%0d", i), 32'(cpu_stall), 32'((i % 5) == 4));
            checkOutput($sformatf("ct_host_rv_%0d", i),   32'(host_rvalid),
                        32'(i > 0 && (i % 5) == 0));
            checkOutput($sformatf("ct_cpu_rv_%0d", i),    32'(cpu_rvalid),
                        32'(i > 0 && (i % 5) != 0));
            if (i > 0 && (i % 5) == 0)
                checkOutput($sformatf("ct_host_rd_%0d", i), host_rdata, 32'h12345678);
            if (i > 0 && (i % 5) != 0)
                checkOutput($sformatf("ct_cpu_rd_%0d", i), cpu_rdata, 32'hDEADBEEF);
        end
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        checkOutput("ct_tail_host_rv", 32'(host_rvalid), 32'd1);
        checkOutput("ct_tail_host_rd", host_rdata,       32'h12345678);

        // Alternating reads: host 0x1, CPU 0x2, host 0x3.
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 1, 32'h1, 32'hA1);
        applyStimulus(1, 1, 32'h2, 32'hB2, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 1, 32'h3, 32'hA3);
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 32'h1, 32'h0);
        applyStimulus(1, 0, 32'h2, 32'h0, 0, 0, 32'h0, 32'h0);
        checkOutput("alt1_host_rv", 32'(host_rvalid), 32'd1);
        checkOutput("alt1_host_rd", host_rdata,       32'hA1);
        checkOutput("alt1_cpu_rv",  32'(cpu_rvalid),  32'd0);
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 32'h3, 32'h0);
        checkOutput("alt2_cpu_rv",   32'(cpu_rvalid),  32'd1);
        checkOutput("alt2_cpu_rd",   cpu_rdata,        32'hB2);
        checkOutput("alt2_host_rv",  32'(host_rvalid), 32'd0);
        checkOutput("alt2_host_hold", host_rdata,      32'hA1);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        checkOutput("alt3_host_rv",  32'(host_rvalid), 32'd1);
        checkOutput("alt3_host_rd",  host_rdata,       32'hA3);
        checkOutput("alt3_cpu_rv",   32'(cpu_rvalid),  32'd0);
        checkOutput("alt3_cpu_hold", cpu_rdata,        32'hB2);

        // CPU writes 0x40, host reads it the very next cycle.
        applyStimulus(1, 1, 32'h40, 32'hCAFE0001, 0, 0, 32'h0, 32'h0);
        applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        checkOutput("raw_host_rd", host_rdata, 32'hCAFE0001);

        // Host-only burst of writes then pipelined read-back.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 32'h0, 32'h0, 1, 1, 32'(i), 32'h100 + 32'(i));
            checkOutput($sformatf("hb_ack_%0d", i), 32'(host_ack), 32'd1);
            checkOutput($sformatf("hb_wait_%0d", i), 32'(dut.wait_cnt), 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 32'(i), 32'h0);
            if (i > 0)
                checkOutput($sformatf("hb_rd_%0d", i - 1), host_rdata, 32'h100 + 32'(i - 1));
        end
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        checkOutput("hb_rd_7", host_rdata, 32'h107);

        // A withdrawn host request restarts the starvation count.
        applyStimulus(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
        applyStimulus(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
        applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
            checkOutput($sformatf("wd_host_ack_%0d", i), 32'(host_ack), 32'(i == 4));
        end

        // Reset arriving while a CPU read is in flight.
        applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
        checkOutput("rm_cpu_stall", 32'(cpu_stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cpu_req = 1'b1;
        #1;
        checkOutput("rm_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        checkOutput("rm_mem_en",     32'(mem_en),     32'd0);
        checkOutput("rm_cpu_stall1", 32'(cpu_stall),  32'd1);
        applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        checkOutput("rm_cpu_rdata",  cpu_rdata,        32'd0);
        checkOutput("rm_state_idle", 32'(dut.state),   32'd0);
        checkOutput("rm_cpu_rv2",    32'(cpu_rvalid),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rm_post_rv", 32'(cpu_rvalid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single-port data SRAM between the CPU pipeline MEM stage and the external host access port.
- Sits between the pipeline's MEM-stage request signals, the host *_ext_2 bus and the data_memory sram instance.
- Issues a stall to the CPU when it loses arbitration.
- Routes 1-cycle-latency read data back to whichever requester owns the returning read.
- Guarantees host forward progress with a starvation counter.

Parameters:
- ADDR_W, 10, SRAM word-address width; request addresses are truncated to this width.
- DATA_W, 32, data word width.
- MAX_WAIT, 4, consecutive lost cycles after which a pending host request wins one cycle; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU MEM-stage access request (mem_read | mem_write).
- cpu_wen  in  1  1 = write, 0 = read.
- cpu_addr  in  32  CPU byte/word address; low ADDR_W bits used.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_stall  out  1  CPU request not granted this cycle; pipeline must hold.
- cpu_rvalid  out  1  cpu_rdata valid this cycle.
- cpu_rdata  out  DATA_W  CPU read data.
- host_req  in  1  host access request.
- host_wen  in  1  1 = write, 0 = read.
- host_addr  in  32  host address; low ADDR_W bits used.
- host_wdata  in  DATA_W  host write data.
- host_ack  out  1  host request granted this cycle.
- host_rvalid  out  1  host_rdata valid this cycle.
- host_rdata  out  DATA_W  host read data.
- mem_en  out  1  SRAM access strobe.
- mem_wen  out  1  SRAM write enable.
- mem_addr  out  ADDR_W  SRAM address.
- mem_wdata  out  DATA_W  SRAM write data.
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after a read strobe.

Behaviour:
- Grant (combinational, same cycle):
  - Only cpu_req: cpu granted.
  - Only host_req: host granted.
  - Both asserted: host granted iff wait_cnt >= MAX_WAIT; otherwise cpu granted.
  - Neither: no grant, mem_en = 0.
- Outputs from grant:
  - cpu_stall = cpu_req & ~cpu_grant.
  - host_ack = host_grant.
  - mem_en = cpu_grant | host_grant.
  - mem_wen / mem_addr / mem_wdata are muxed from the granted requester; all zero when no grant.
- wait_cnt (4-bit, registered):
  - host_req & ~host_grant: increment, saturating at MAX_WAIT.
  - host_grant or ~host_req: clear to 0.
- Read-return FSM, registered owner of the read in flight:
  - States: IDLE, CPU_RD, HOST_RD.
  - Next state each cycle: CPU_RD if cpu_grant & ~cpu_wen; HOST_RD if host_grant & ~host_wen; else IDLE.
  - Transitions are legal from any state, since back-to-back reads are fully pipelined.
  - In CPU_RD: cpu_rvalid = 1, cpu_rdata = mem_rdata. In HOST_RD: likewise for host.
  - Non-owner rdata output is held at its last value.
  - Read latency: grant in cycle N gives rvalid in cycle N+1.
- Writes: complete in the grant cycle; no rvalid is generated.
- Reset (rst = 1 at an edge):
  - FSM goes to IDLE, wait_cnt = 0, cpu_rdata = host_rdata = 0.
  - While rst is high, all grants are forced to 0: mem_en = 0, host_ack = 0, cpu_stall = cpu_req.
  - A read granted in the cycle before reset returns no rvalid.
- Boundary conditions:
  - Same-address write by one requester followed by read by the other next cycle: the read returns the new data (SRAM write-first ordering is not needed; the write commits at the edge).
  - Host starving under a continuous CPU stream: the host wins exactly every (MAX_WAIT+1)th cycle.
  - A host request withdrawn before grant is not remembered.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with cpu_req=host_req=1 -> mem_en=0, host_ack=0, cpu_stall=1, rvalids=0, rdata=0; after release the CPU is granted first.
- CPU-only write then read: write 0xDEADBEEF to addr 0x10, next cycle read 0x10 -> cpu_stall=0 both cycles; cpu_rvalid=1 with cpu_rdata=0xDEADBEEF one cycle after the read grant; host_rvalid stays 0.
- Contention, MAX_WAIT=4: cpu_req and host_req (read addr 0x20 = 0x12345678) held high -> CPU granted cycles 0-3, host_ack=1 and cpu_stall=1 in cycle 4, host_rvalid=1 with 0x12345678 in cycle 5, pattern repeats with period 5.
- Back-to-back alternating reads: host read 0x1, CPU read 0x2, host read 0x3 on consecutive grants -> rvalids alternate host/cpu/host on cycles N+1..N+3 with the matching data; no data crosses to the wrong port.
- Host-only burst: 8 host writes to addresses 0..7 with cpu_req=0 -> host_ack=1 every cycle, wait_cnt stays 0, SRAM contents readable via subsequent host reads.
- Reset mid-read: CPU read granted in cycle N, rst=1 in cycle N+1 -> cpu_rvalid=0 in cycle N+1, FSM in IDLE, cpu_rdata=0.
